// File: rtl/spi_ram_loader.sv
// SPI mode-0 slave that loads and reads back the CPU's single-port RAM.
// Owns the RAM port and holds the CPU for the duration of each frame.
module spi_ram_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  cpu_hold,
    output logic [15:0]           wr_count,
    output logic                  frame_err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        ADDR    = 3'd2,
        WRITE   = 3'd3,
        READ    = 3'd4,
        DISCARD = 3'd5
    } state_t;

    localparam logic [4:0] LAST_BYTE_BIT = 5'd7;
    localparam logic [4:0] LAST_WORD_BIT = 5'(DATA_WIDTH - 1);

    state_t                  state_r;
    logic [2:0]              sclk_sync_r;
    logic [2:0]              cs_sync_r;
    logic [1:0]              mosi_sync_r;
    logic [4:0]              bit_cnt_r;
    logic [7:0]              byte_r;
    logic [DATA_WIDTH-1:0]   wshreg_r;
    logic [DATA_WIDTH-1:0]   shreg_r;
    logic [ADDR_WIDTH-1:0]   ptr_r;
    logic                    is_read_r;
    logic                    wr_pend_r;

    logic                    rise_s, fall_s, cs_fall_s, cs_rise_s, mosi_s;
    logic                    active_s, byte_done_s, word_done_s, end_s, abort_err_s;
    logic [4:0]              cnt_after_s;
    logic [7:0]              byte_next_s;
    logic [DATA_WIDTH-1:0]   word_next_s;
    logic [ADDR_WIDTH-1:0]   addr_new_s;

    assign rise_s      = sclk_sync_r[1] & ~sclk_sync_r[2];
    assign fall_s      = ~sclk_sync_r[1] & sclk_sync_r[2];
    assign cs_fall_s   = ~cs_sync_r[1] & cs_sync_r[2];
    assign cs_rise_s   = cs_sync_r[1] & ~cs_sync_r[2];
    assign mosi_s      = mosi_sync_r[1];
    assign byte_next_s = {byte_r[6:0], mosi_s};
    assign word_next_s = {wshreg_r[DATA_WIDTH-2:0], mosi_s};
    assign addr_new_s  = byte_next_s[ADDR_WIDTH-1:0];
    assign miso        = (state_r == READ) & shreg_r[DATA_WIDTH-1];

    // Edge qualification, address bypass and abort classification.
    always_comb begin
        active_s    = 1'b0;
        byte_done_s = 1'b0;
        word_done_s = 1'b0;
        cnt_after_s = bit_cnt_r;
        mem_addr    = ptr_r;
        if ((state_r == CMD) || (state_r == ADDR)) begin
            active_s    = 1'b1;
            byte_done_s = rise_s && (bit_cnt_r == LAST_BYTE_BIT);
        end else if ((state_r == WRITE) || (state_r == READ)) begin
            active_s    = 1'b1;
            word_done_s = rise_s && (bit_cnt_r == LAST_WORD_BIT);
        end else begin
            active_s    = 1'b0;
        end
        if (active_s && rise_s) begin
            cnt_after_s = (byte_done_s || word_done_s) ? 5'd0 : bit_cnt_r + 5'd1;
        end else begin
            cnt_after_s = bit_cnt_r;
        end
        // The read prefetch must see the incoming address in the same cycle.
        if ((state_r == ADDR) && byte_done_s) begin
            mem_addr = addr_new_s;
        end else begin
            mem_addr = ptr_r;
        end
        end_s       = cs_rise_s && (state_r != IDLE);
        abort_err_s = active_s && ((cnt_after_s != 5'd0) || (state_r == ADDR));
    end

    // Input synchronizers with one extra history stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_r <= 3'd0;
            cs_sync_r   <= 3'd0;
            mosi_sync_r <= 2'd0;
        end else begin
            sclk_sync_r <= {sclk_sync_r[1:0], sclk};
            cs_sync_r   <= {cs_sync_r[1:0], cs_n};
            mosi_sync_r <= {mosi_sync_r[0], mosi};
        end
    end

    // Frame FSM, RAM write pulse, pointer and write counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            bit_cnt_r <= 5'd0;
            byte_r    <= 8'd0;
            wshreg_r  <= '0;
            shreg_r   <= '0;
            ptr_r     <= '0;
            is_read_r <= 1'b0;
            wr_pend_r <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            cpu_hold  <= 1'b0;
            wr_count  <= 16'd0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            if (wr_pend_r) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                wr_pend_r <= 1'b0;
            end
            if (mem_en) begin
                ptr_r <= ptr_r + ADDR_WIDTH'(1);
                if (wr_count != 16'hFFFF) begin
                    wr_count <= wr_count + 16'd1;
                end
                // A word that completed as the frame closed keeps the CPU held until written.
                if (state_r == IDLE) begin
                    cpu_hold <= 1'b0;
                end
            end
            case (state_r)
                IDLE: begin
                    if (cs_fall_s) begin
                        state_r   <= CMD;
                        bit_cnt_r <= 5'd0;
                        cpu_hold  <= 1'b1;
                    end
                end
                CMD: begin
                    if (rise_s) begin
                        byte_r    <= byte_next_s;
                        bit_cnt_r <= cnt_after_s;
                        if (byte_done_s) begin
                            case (byte_next_s)
                                8'h01: begin
                                    is_read_r <= 1'b0;
                                    state_r   <= ADDR;
                                end
                                8'h02: begin
                                    is_read_r <= 1'b1;
                                    state_r   <= ADDR;
                                end
                                default: state_r <= DISCARD;
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (rise_s) begin
                        byte_r    <= byte_next_s;
                        bit_cnt_r <= cnt_after_s;
                        if (byte_done_s) begin
                            if (is_read_r) begin
                                state_r <= READ;
                                shreg_r <= mem_rdata;
                                ptr_r   <= addr_new_s + ADDR_WIDTH'(1);
                            end else begin
                                state_r <= WRITE;
                                ptr_r   <= addr_new_s;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (rise_s) begin
                        wshreg_r  <= word_next_s;
                        bit_cnt_r <= cnt_after_s;
                        if (word_done_s) begin
                            mem_wdata <= word_next_s;
                            wr_pend_r <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (rise_s) begin
                        bit_cnt_r <= cnt_after_s;
                        if (word_done_s) begin
                            shreg_r <= mem_rdata;
                            ptr_r   <= ptr_r + ADDR_WIDTH'(1);
                        end
                    end else if (fall_s && (bit_cnt_r != 5'd0)) begin
                        shreg_r <= {shreg_r[DATA_WIDTH-2:0], 1'b0};
                    end
                end
                DISCARD: begin
                    bit_cnt_r <= 5'd0;
                end
                default: state_r <= IDLE;
            endcase
            if (end_s) begin
                state_r   <= IDLE;
                bit_cnt_r <= 5'd0;
                frame_err <= abort_err_s;
                cpu_hold  <= (state_r == WRITE) && word_done_s;
            end
        end
    end

endmodule
